stpm_cmd_parser: RTL and testbench
==================================

// Module: stpm_cmd_parser
// PURPOSE
//  Keypad-token command parser; producer side of the stepper controller's command interface (Dir/En/Cycles).
//  Takes 4-bit decoded-key tokens (digit 0-9, SPACE, ENTER, FORWARD, BACKWARD) framed as "<motor> SPACE <FWD|BWD> <deg> ENTER".
//  Converts degrees to step cycles as floor(deg*5/9) (1.8 deg/step), then drives held outputs for stpm_full.
// PARAMETERS
//  MAX_DEG      360         largest accepted angle; larger -> error
//  TIMEOUT_CYC  50_000_000  idle cycles mid-command before abort (only with STPM_CMD_TIMEOUT_EN)
// PORTS
//  i_Clk     in   1   clock
//  i_Rst     in   1   synchronous active-high reset
//  i_Data    in   4   token: 0-9 digit, 10 SPACE, 11 ENTER, 12 FORWARD, 13 BACKWARD, 14/15 invalid
//  i_Ena     in   1   token strobe; rising edge samples i_Data
//  o_Dir     out  1   0 forward, 1 backward (held)
//  o_En      out  4   active-low motor enable, one-cold: motor n -> bit n-1 low (held)
//  o_Cycles  out  10  step cycles (held)
//  o_Valid   out  1   1-cycle pulse when o_Dir/o_En/o_Cycles update
//  o_Err     out  1   1-cycle pulse on rejected command
//  o_Busy    out  1   high during S_CONV
// BEHAVIOUR
//  Reset: o_Dir=0, o_En=4'b1111, o_Cycles=0, o_Valid=0, o_Err=0, o_Busy=0, state S_MOTOR, digit count 0. Applies mid-conversion too.
//  Token accepted once per i_Ena rising edge (registered edge detect); i_Ena held high = one token.
//  FSM: S_MOTOR: digit 1-4 -> latch motor, S_SPACE; other -> stay, no error.
//   S_SPACE: SPACE -> S_DIR.   S_DIR: FORWARD/BACKWARD -> latch dir, S_DEG.
//   S_DEG: digit -> deg = deg*10 + d (max 3 digits); ENTER with >=1 digit -> S_CONV.
//   S_CONV: restoring division (deg*5)/9, 11-bit dividend, one bit/cycle, 11 cycles; then commit -> S_MOTOR.
//  Error (o_Err pulse, -> S_MOTOR, outputs unchanged): wrong token in S_SPACE/S_DIR/S_DEG, 4th digit, ENTER with 0 digits,
//   deg==0 or deg>MAX_DEG at ENTER.
//  Latency: ENTER sampled at edge k -> outputs + o_Valid at edge k+12.
//  Tokens arriving during S_CONV are dropped silently (no error).
//  Outputs held until next commit or reset; new commit overwrites all three at once (one-cold En replaces previous).
//  deg register 10 bits; deg*5 computed as (deg<<2)+deg, 11 bits; quotient <= 200 for MAX_DEG=360.
// CONFIGURATION
//  STPM_CMD_TIMEOUT_EN defined: counter clears on every accepted token; TIMEOUT_CYC cycles without a token
//   while not in S_MOTOR/S_CONV -> o_Err pulse, return to S_MOTOR. Counter idle in S_MOTOR.
//  Undefined: no counter; a partial command waits indefinitely.
// STRUCTURE
//  stpm_pkg: token localparams (SPACE, ENTER, FORWARD, BACKWARD, INVALID), state enum, DEG_NUM=5, DEG_DEN=9.
//  Sub-module stpm_deg2cyc: start/done sequential (deg*5)/9 divider, 11-cycle fixed latency.
// TESTING
//  Tokens 2,SPACE,FORWARD,1,2,8,ENTER -> 12 cycles later o_Valid, o_En=4'b1101, o_Dir=0, o_Cycles=71.
//  1,SPACE,BACKWARD,8,7,ENTER then 4,SPACE,FORWARD,7,ENTER -> o_En=1110/Dir=1/Cycles=48, then o_En=0111/Dir=0/Cycles=3.
//  3,SPACE,BACKWARD,4,0,0,ENTER (400>360) and 3,SPACE,1 -> o_Err each; outputs keep previous values.
//  i_Ena held 20 cycles on digit 5 in S_DEG, then ENTER -> deg=5, o_Cycles=2 (single token).
//  i_Rst asserted in S_CONV -> next edge all outputs at reset values, o_Valid never pulses.
//  STPM_CMD_TIMEOUT_EN, TIMEOUT_CYC=100: 1,SPACE then 100 idle cycles -> o_Err, state S_MOTOR.

Source files
------------

// File: rtl/stpm_pkg.sv
// rtl/stpm_pkg.sv - shared tokens, parser states and degree-to-step constants for the stepper command path
package stpm_pkg;

  localparam logic [3:0] TOK_SPACE    = 4'd10;
  localparam logic [3:0] TOK_ENTER    = 4'd11;
  localparam logic [3:0] TOK_FORWARD  = 4'd12;
  localparam logic [3:0] TOK_BACKWARD = 4'd13;
  localparam logic [3:0] TOK_INVALID  = 4'd14;

  localparam int DEG_NUM   = 5;
  localparam int DEG_DEN   = 9;
  localparam int DEG_W     = 10;
  localparam int DIV_W     = 11;
  localparam int DIV_STEPS = 11;

  typedef enum logic [2:0] {
    S_MOTOR,
    S_SPACE,
    S_DIR,
    S_DEG,
    S_CONV
  } state_t;

  function automatic logic is_digit(input logic [3:0] tok);
    return tok < TOK_SPACE;
  endfunction

  function automatic logic is_token(input logic [3:0] tok);
    return tok < TOK_INVALID;
  endfunction

endpackage

// File: rtl/stpm_deg2cyc.sv
// rtl/stpm_deg2cyc.sv - sequential restoring divider producing floor(deg*5/9), fixed 11-cycle latency
module stpm_deg2cyc
  import stpm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEG_W-1:0] deg,
  output logic             done,
  output logic [DEG_W-1:0] cycles
);

  localparam int NUM_SHIFT = $clog2(DEG_NUM - 1);

  logic [DIV_W-1:0] dvd;
  logic [3:0]       rem;
  logic [3:0]       cnt;
  logic             run;
  logic [DIV_W-1:0] deg_ext;
  logic [4:0]       trial;
  logic             ge;

  assign deg_ext = {1'b0, deg};
  // dividend bits leave at the top while quotient bits enter at the bottom
  assign trial   = {rem, dvd[DIV_W-1]};
  assign ge      = trial >= 5'(DEG_DEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0;
      rem <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      dvd <= (deg_ext << NUM_SHIFT) + deg_ext;
      rem <= '0;
      cnt <= 4'(DIV_STEPS);
      run <= 1'b1;
    end else if (run) begin
      if (cnt != 4'd0) begin
        rem <= ge ? 4'(trial - 5'(DEG_DEN)) : trial[3:0];
        dvd <= {dvd[DIV_W-2:0], ge};
        cnt <= cnt - 4'd1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done   = run && (cnt == 4'd0);
  assign cycles = dvd[DEG_W-1:0];

endmodule

// File: rtl/stpm_cmd_parser.sv
// rtl/stpm_cmd_parser.sv - keypad token parser driving Dir/En/Cycles for the stepper controller
module stpm_cmd_parser
  import stpm_pkg::*;
#(
  parameter int MAX_DEG     = 360,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [3:0]       i_Data,
  input  logic             i_Ena,
  output logic             o_Dir,
  output logic [3:0]       o_En,
  output logic [DEG_W-1:0] o_Cycles,
  output logic             o_Valid,
  output logic             o_Err,
  output logic             o_Busy
);

  state_t           state, state_n;
  logic             ena_q;
  logic             tok;
  logic [1:0]       motor, motor_n;
  logic             dir, dir_n;
  logic [DEG_W-1:0] deg, deg_n;
  logic [1:0]       ndig, ndig_n;
  logic             err_n;
  logic             commit;
  logic             div_start;
  logic             div_done;
  logic [DEG_W-1:0] div_cycles;
  logic             timeout;

  assign tok = i_Ena && !ena_q;

`ifdef STPM_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || tok || state == S_MOTOR || state == S_CONV) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = !tok && state != S_MOTOR && state != S_CONV
                   && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    motor_n   = motor;
    dir_n     = dir;
    deg_n     = deg;
    ndig_n    = ndig;
    err_n     = 1'b0;
    commit    = 1'b0;
    div_start = 1'b0;
    case (state)
      S_MOTOR: begin
        if (tok && is_token(i_Data) && i_Data >= 4'd1 && i_Data <= 4'd4) begin
          motor_n = i_Data[1:0] - 2'd1;
          deg_n   = '0;
          ndig_n  = '0;
          state_n = S_SPACE;
        end
      end
      S_SPACE: begin
        if (tok) begin
          if (i_Data == TOK_SPACE) state_n = S_DIR;
          else                     err_n   = 1'b1;
        end
      end
      S_DIR: begin
        if (tok) begin
          if (i_Data == TOK_FORWARD) begin
            dir_n   = 1'b0;
            state_n = S_DEG;
          end else if (i_Data == TOK_BACKWARD) begin
            dir_n   = 1'b1;
            state_n = S_DEG;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_DEG: begin
        if (tok) begin
          if (is_digit(i_Data)) begin
            if (ndig == 2'd3) begin
              err_n = 1'b1;
            end else begin
              deg_n  = (deg << 3) + (deg << 1) + DEG_W'(i_Data);
              ndig_n = ndig + 2'd1;
            end
          end else if (i_Data == TOK_ENTER) begin
            if (ndig == 2'd0 || deg == '0 || deg > DEG_W'(MAX_DEG)) begin
              err_n = 1'b1;
            end else begin
              div_start = 1'b1;
              state_n   = S_CONV;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_CONV: begin
        // tokens are ignored here; only the divider finishing moves us on
        if (div_done) begin
          commit  = 1'b1;
          state_n = S_MOTOR;
        end
      end
      default: state_n = S_MOTOR;
    endcase
    if (timeout) err_n = 1'b1;
    if (err_n) state_n = S_MOTOR;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= S_MOTOR;
      ena_q    <= 1'b0;
      motor    <= '0;
      dir      <= 1'b0;
      deg      <= '0;
      ndig     <= '0;
      o_Dir    <= 1'b0;
      o_En     <= 4'b1111;
      o_Cycles <= '0;
      o_Valid  <= 1'b0;
      o_Err    <= 1'b0;
    end else begin
      state   <= state_n;
      ena_q   <= i_Ena;
      motor   <= motor_n;
      dir     <= dir_n;
      deg     <= deg_n;
      ndig    <= ndig_n;
      o_Valid <= commit;
      o_Err   <= err_n;
      if (commit) begin
        o_Dir    <= dir;
        o_En     <= ~(4'b0001 << motor);
        o_Cycles <= div_cycles;
      end
    end
  end

  assign o_Busy = (state == S_CONV);

  stpm_deg2cyc u_deg2cyc (
    .clk    (i_Clk),
    .rst    (i_Rst),
    .start  (div_start),
    .deg    (deg),
    .done   (div_done),
    .cycles (div_cycles)
  );

endmodule

// File: tb/tb_stpm_cmd_parser.sv
// tb/tb_stpm_cmd_parser.sv - scoreboard bench for the keypad command parser
module tb_stpm_cmd_parser;

  localparam int SP = 10, ENT = 11, FW = 12, BW = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       ena;
  logic       dir;
  logic [3:0] en;
  logic [9:0] cycles;
  logic       valid, err, busy;

  typedef struct {
    bit       is_err;
    bit [3:0] en;
    bit       dir;
    int       cyc;
    int       lat;
  } exp_t;

  exp_t sb[$];
  int   seq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_tok_cyc = 0;
  bit [3:0] m_en = 4'b1111;
  bit       m_dir = 1'b0;
  int       m_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stpm_cmd_parser #(.MAX_DEG(360), .TIMEOUT_CYC(100)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Data   (data),
    .i_Ena    (ena),
    .o_Dir    (dir),
    .o_En     (en),
    .o_Cycles (cycles),
    .o_Valid  (valid),
    .o_Err    (err),
    .o_Busy   (busy)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_ok(input int motor, input bit d, input int deg);
    exp_t e;
    e.is_err = 1'b0;
    e.en     = ~(4'b0001 << (motor - 1));
    e.dir    = d;
    e.cyc    = (deg * 5) / 9;
    e.lat    = 12;
    sb.push_back(e);
  endtask

  task automatic push_err(input int lat);
    exp_t e;
    e.is_err = 1'b1;
    e.en     = 4'b0;
    e.dir    = 1'b0;
    e.cyc    = 0;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  // track=0 sends a token that must not move the latency reference
  task automatic send_tok(input int t, input bit track);
    data = 4'(t);
    ena  = 1'b1;
    if (track) last_tok_cyc = cyc + 1;
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
  endtask

  task automatic play();
    foreach (seq[i]) send_tok(seq[i], 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && (valid || err)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind_err", int'(err), int'(e.is_err));
        check("event_kind_valid", int'(valid), int'(!e.is_err));
        check("latency", cyc - last_tok_cyc, e.lat);
        if (!e.is_err) begin
          m_en  = e.en;
          m_dir = e.dir;
          m_cyc = e.cyc;
        end
        check("o_En", int'(en), int'(m_en));
        check("o_Dir", int'(dir), int'(m_dir));
        check("o_Cycles", int'(cycles), m_cyc);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    ena  = 1'b0;
    data = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_en", int'(en), 4'b1111);
    check("rst_dir", int'(dir), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_valid_err", int'({valid, err}), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    push_ok(2, 0, 128);
    seq = '{2, SP, FW, 1, 2, 8, ENT};
    play();
    check("busy_in_conv", int'(busy), 1);
    repeat (14) @(negedge clk);
    check("busy_after", int'(busy), 0);

    push_ok(1, 1, 87);
    seq = '{1, SP, BW, 8, 7, ENT};
    play();
    repeat (14) @(negedge clk);
    push_ok(4, 0, 7);
    seq = '{4, SP, FW, 7, ENT};
    play();
    repeat (14) @(negedge clk);

    push_err(0);
    seq = '{3, SP, BW, 4, 0, 0, ENT};
    play();
    push_err(0);
    seq = '{3, SP, 1};
    play();
    push_err(0);
    seq = '{2, FW};
    play();
    repeat (3) @(negedge clk);

    seq = '{2, SP, FW};
    play();
    data = 4'd5;
    ena  = 1'b1;
    last_tok_cyc = cyc + 1;
    repeat (20) @(negedge clk);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    push_ok(2, 0, 5);
    send_tok(ENT, 1'b1);
    repeat (14) @(negedge clk);

    push_ok(1, 1, 360);
    seq = '{1, SP, BW, 3, 6, 0, ENT};
    play();
    repeat (14) @(negedge clk);
    push_err(0);
    seq = '{1, SP, FW, 3, 6, 1, ENT};
    play();
    push_err(0);
    seq = '{1, SP, FW, 1, 2, 3, 4};
    play();
    push_err(0);
    seq = '{2, SP, FW, ENT};
    play();
    push_err(0);
    seq = '{2, SP, FW, 0, ENT};
    play();
    push_ok(3, 0, 9);
    seq = '{5, 0, 14, SP, 3, SP, FW, 9, ENT};
    play();
    repeat (14) @(negedge clk);

    push_ok(2, 1, 18);
    seq = '{2, SP, BW, 1, 8, ENT};
    play();
    send_tok(1, 1'b0);
    send_tok(ENT, 1'b0);
    repeat (14) @(negedge clk);
    push_ok(4, 0, 27);
    seq = '{4, SP, FW, 2, 7, ENT};
    play();
    repeat (14) @(negedge clk);

    seq = '{1, SP, FW, 9, 0, ENT};
    play();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("conv_rst_en", int'(en), 4'b1111);
    check("conv_rst_dir", int'(dir), 0);
    check("conv_rst_cycles", int'(cycles), 0);
    check("conv_rst_busy", int'(busy), 0);
    rst   = 1'b0;
    m_en  = 4'b1111;
    m_dir = 1'b0;
    m_cyc = 0;
    repeat (16) @(negedge clk);

`ifdef STPM_CMD_TIMEOUT_EN
    push_err(100);
    seq = '{1, SP};
    play();
    repeat (105) @(negedge clk);
    push_ok(2, 0, 18);
    seq = '{2, SP, FW, 1, 8, ENT};
    play();
    repeat (14) @(negedge clk);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
